uart_tx_16x: RTL

- UART transmitter, the transmit-side counterpart of the team's 16x-oversampled UART receiver.
- Serialises bytes onto `tx` at one bit per 16 rising edges of the shared `clk_16x` baud strobe.
- Format: start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
- One-entry holding register: the next byte can be queued while the current frame shifts, so back-to-back frames have no idle gap.

---
 rtl/uart_tx_16x_if.sv | 21 ++
 rtl/uart_tx_16x.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_16x_if.sv
// Byte-write and serial-line bundle for the 16x-oversampled UART transmitter.
// master drives the baud strobe and writes; slave is the transmitter side.
interface uart_tx_16x_if;
  logic       clk_16x;
  logic       wr_en;
  logic [7:0] din;
  logic       wr_rdy;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output clk_16x, wr_en, din,
    input  wr_rdy, tx, busy, done
  );

  modport slave (
    input  clk_16x, wr_en, din,
    output wr_rdy, tx, busy, done
  );
endinterface

// File: rtl/uart_tx_16x.sv
// UART transmitter: start, 8 data LSB-first, optional parity, 1/2 stop; 16 baud ticks per bit.
// One-entry holding register lets the next byte queue during a frame; wr_rdy low while it is full.
module uart_tx_16x #(
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_16x_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  state_t     r_state, w_state_nxt;
  logic       r_clk16_d;
  logic [7:0] r_hold;
  logic       r_hold_valid, w_hold_valid_nxt;
  logic [7:0] r_shifter, w_shifter_nxt;
  logic [3:0] r_sample, w_sample_nxt;
  logic [2:0] r_bitpos, w_bitpos_nxt;
  logic       r_stop_cnt, w_stop_cnt_nxt;
  logic       r_tx, w_tx_nxt;
  logic       r_done, w_done_nxt;
  logic       r_busy, w_busy_nxt;
  logic       w_tick, w_wr_acc, w_load, w_parity, w_bit_end;
  logic [2:0] w_bitpos_inc;

  assign w_tick       = bus.clk_16x & ~r_clk16_d;
  assign w_wr_acc     = bus.wr_en & ~r_hold_valid;
  assign w_parity     = (^r_shifter) ^ PARITY_ODD;
  assign w_bit_end    = (r_sample == 4'd15);
  assign w_bitpos_inc = r_bitpos + 3'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_shifter_nxt  = r_shifter;
    w_sample_nxt   = r_sample;
    w_bitpos_nxt   = r_bitpos;
    w_stop_cnt_nxt = r_stop_cnt;
    w_tx_nxt       = r_tx;
    w_done_nxt     = 1'b0;
    w_load         = 1'b0;
    if (w_tick) begin
      // sample wraps 15 -> 0 on its own, which is exactly the bit boundary
      if (r_state != S_IDLE) w_sample_nxt = r_sample + 4'd1;
      case (r_state)
        S_IDLE: begin
          if (r_hold_valid) w_load = 1'b1;
        end
        S_START: begin
          if (w_bit_end) begin
            w_tx_nxt     = r_shifter[0];
            w_bitpos_nxt = 3'd0;
            w_state_nxt  = S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bitpos != 3'd7) begin
              w_bitpos_nxt = w_bitpos_inc;
              w_tx_nxt     = r_shifter[w_bitpos_inc];
            end else if (PARITY_EN) begin
              w_tx_nxt    = w_parity;
              w_state_nxt = S_PARITY;
            end else begin
              w_tx_nxt       = 1'b1;
              w_stop_cnt_nxt = 1'b0;
              w_state_nxt    = S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            w_tx_nxt       = 1'b1;
            w_stop_cnt_nxt = 1'b0;
            w_state_nxt    = S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_stop_cnt == LAST_STOP) begin
              w_done_nxt = 1'b1;
              if (r_hold_valid) w_load = 1'b1;
              else              w_state_nxt = S_IDLE;
            end else begin
              w_stop_cnt_nxt = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      // a queued byte chains straight into the next start bit
      if (w_load) begin
        w_shifter_nxt = r_hold;
        w_tx_nxt      = 1'b0;
        w_sample_nxt  = 4'd0;
        w_state_nxt   = S_START;
      end
    end
    w_hold_valid_nxt = w_load ? 1'b0 : (w_wr_acc ? 1'b1 : r_hold_valid);
    w_busy_nxt       = (w_state_nxt != S_IDLE) | w_hold_valid_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_clk16_d    <= 1'b0;
      r_hold_valid <= 1'b0;
      r_shifter    <= 8'd0;
      r_sample     <= 4'd0;
      r_bitpos     <= 3'd0;
      r_stop_cnt   <= 1'b0;
      r_tx         <= 1'b1;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clk16_d    <= bus.clk_16x;
      r_hold_valid <= w_hold_valid_nxt;
      r_shifter    <= w_shifter_nxt;
      r_sample     <= w_sample_nxt;
      r_bitpos     <= w_bitpos_nxt;
      r_stop_cnt   <= w_stop_cnt_nxt;
      r_tx         <= w_tx_nxt;
      r_done       <= w_done_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_hold <= 8'd0;
    else if (w_wr_acc) r_hold <= bus.din;
  end

  assign bus.wr_rdy = ~r_hold_valid;
  assign bus.tx     = r_tx;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule
